// File: rtl/instr_seq_ctrl_if.sv
// Control bus between instr_seq_ctrl (master) and the ROM / regfile / ALU / data-memory
// datapath (slave). Widths follow the controller parameters.
interface instr_seq_ctrl_if #(
  parameter int PC_W   = 8,
  parameter int REG_AW = 3,
  parameter int IMM_W  = 9
);
  logic [PC_W-1:0]   rom_addr;
  logic [15:0]       rom_data;
  logic [REG_AW-1:0] rf_ra;
  logic [REG_AW-1:0] rf_rb;
  logic [REG_AW-1:0] rf_wa;
  logic              rf_we;
  logic              rf_wsel;
  logic              alu_bsel;
  logic [IMM_W-1:0]  imm;
  logic              mem_we;
  logic              mem_re;

  modport master (
    output rom_addr, rf_ra, rf_rb, rf_wa, rf_we, rf_wsel, alu_bsel, imm, mem_we, mem_re,
    input  rom_data
  );

  modport slave (
    input  rom_addr, rf_ra, rf_rb, rf_wa, rf_we, rf_wsel, alu_bsel, imm, mem_we, mem_re,
    output rom_data
  );
endinterface

// File: rtl/instr_seq_ctrl.sv
// Multi-cycle sequencer for the 16-bit ROM datapath (NOP/ADD/ADDI/ST/LD/HALT).
// Optional single-step gating of every fetch is enabled by defining STEP_EN.
module instr_seq_ctrl #(
  parameter int PC_W   = 8,
  parameter int REG_AW = 3,
  parameter int IMM_W  = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
`ifdef STEP_EN
  input  logic step,
`endif
  instr_seq_ctrl_if.master bus,
  output logic busy,
  output logic halted,
  output logic illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
`ifdef STEP_EN
    , S_STEP
`endif
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t            state_q, state_d;
  state_t            fetch_entry;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [3:0]        opcode;

  assign opcode = ir_q[15:12];

  // Every path into FETCH goes through fetch_entry so step gating lives in one place.
`ifdef STEP_EN
  assign fetch_entry = S_STEP;
`else
  assign fetch_entry = S_FETCH;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = fetch_entry;
          pc_d    = '0;
        end
      end
`ifdef STEP_EN
      S_STEP: begin
        if (step) state_d = S_FETCH;
      end
`endif
      S_FETCH: begin
        ir_d    = bus.rom_data;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = fetch_entry;
        pc_d    = pc_q + PC_W'(1);
        case (opcode)
          OP_ADD, OP_ADDI: state_d = S_EXEC;
          OP_ST, OP_LD:    state_d = S_MEM;
          OP_HALT: begin
            state_d = S_HALT;
            pc_d    = pc_q;
          end
          default: state_d = fetch_entry;
        endcase
      end
      S_EXEC:  state_d = S_WB;
      S_MEM:   state_d = (opcode == OP_LD) ? S_WB : fetch_entry;
      S_WB:    state_d = fetch_entry;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode only state_q and ir_q, so ROM data never reaches them combinationally.
  assign bus.rom_addr = pc_q;
  assign bus.rf_ra    = ir_q[11 -: REG_AW];
  assign bus.rf_rb    = ir_q[8 -: REG_AW];
  assign bus.rf_wa    = ir_q[11 -: REG_AW];
  assign bus.imm      = ir_q[IMM_W-1:0];
  assign bus.rf_we    = (state_q == S_WB);
  assign bus.rf_wsel  = (state_q == S_WB) && (opcode == OP_LD);
  assign bus.alu_bsel = ((state_q == S_EXEC) || (state_q == S_WB)) && (opcode == OP_ADDI);
  assign bus.mem_we   = (state_q == S_MEM) && (opcode == OP_ST);
  assign bus.mem_re   = (state_q == S_MEM) && (opcode == OP_LD);

  assign busy    = !((state_q == S_IDLE) || (state_q == S_HALT));
  assign halted  = (state_q == S_HALT);
  assign illegal = (state_q == S_DECODE) && (opcode > OP_LD) && (opcode < OP_HALT);

endmodule
